// File: rtl/sp_arbiter_ctrl_if.sv
// Bundle of requester handshakes, stack RAM port and status flags for sp_arbiter_ctrl.
// The slave modport is the controller side; the master modport is the requester/RAM side.
interface sp_arbiter_ctrl_if #(
   parameter int SP_W   = 5,
   parameter int DATA_W = 32
) ();
   logic              a_req;
   logic              a_op;
   logic [DATA_W-1:0] a_wdata;
   logic              a_gnt;
   logic              a_done;
   logic              a_err;
   logic [DATA_W-1:0] a_rdata;

   logic              b_req;
   logic              b_op;
   logic [DATA_W-1:0] b_wdata;
   logic              b_gnt;
   logic              b_done;
   logic              b_err;
   logic [DATA_W-1:0] b_rdata;

   logic              mem_we;
   logic              mem_re;
   logic [SP_W-1:0]   mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic [SP_W-1:0]   sp_out;
   logic              full;
   logic              empty;
   logic              fault;
   logic              fault_clr;

   modport slave (
      input  a_req, a_op, a_wdata, b_req, b_op, b_wdata, mem_rdata, fault_clr,
      output a_gnt, a_done, a_err, a_rdata, b_gnt, b_done, b_err, b_rdata,
      output mem_we, mem_re, mem_addr, mem_wdata, sp_out, full, empty, fault
   );

   modport master (
      output a_req, a_op, a_wdata, b_req, b_op, b_wdata, mem_rdata, fault_clr,
      input  a_gnt, a_done, a_err, a_rdata, b_gnt, b_done, b_err, b_rdata,
      input  mem_we, mem_re, mem_addr, mem_wdata, sp_out, full, empty, fault
   );
endinterface

// File: rtl/sp_arbiter_ctrl.sv
// Stack pointer owner that shares one synchronous stack RAM between two round-robin
// requesters (A = decode PUSH/POP, B = branch CALL/RET), flagging over/underflow.
module sp_arbiter_ctrl #(
   parameter int SP_W   = 5,
   parameter int DATA_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   sp_arbiter_ctrl_if.slave bus
);
   typedef enum logic [2:0] {IDLE, PUSH, POP_RD, POP_CAP, REJECT} state_t;

   localparam logic [SP_W-1:0] SP_ONE = SP_W'(1);

   state_t            state_reg, state_next;
   logic [SP_W-1:0]   sp_reg, sp_next;
   logic              last_reg, last_next;      // 0 = A, 1 = B
   logic              fault_reg, fault_next;
   logic [1:0]        gnt_reg, gnt_next;
   logic [1:0]        done_reg, done_next;
   logic [1:0]        err_reg, err_next;
   logic [DATA_W-1:0] rdata_reg  [2];
   logic [DATA_W-1:0] rdata_next [2];
   logic              mem_we_reg, mem_we_next;
   logic              mem_re_reg, mem_re_next;
   logic [SP_W-1:0]   mem_addr_reg, mem_addr_next;
   logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;

   logic [1:0]        req;
   logic              sel;
   logic              sel_op;
   logic [DATA_W-1:0] sel_wdata;
   logic              full;
   logic              empty;

   assign req       = {bus.b_req, bus.a_req};
   // On contention the side that did not win last time goes first.
   assign sel       = (&req) ? ~last_reg : req[1];
   assign sel_op    = sel ? bus.b_op    : bus.a_op;
   assign sel_wdata = sel ? bus.b_wdata : bus.a_wdata;
   assign full      = (sp_reg == '1);
   assign empty     = (sp_reg == '0);

   always_comb begin
      state_next     = state_reg;
      sp_next        = sp_reg;
      last_next      = last_reg;
      fault_next     = fault_reg & ~bus.fault_clr;
      gnt_next       = '0;
      done_next      = '0;
      err_next       = '0;
      rdata_next     = rdata_reg;
      mem_we_next    = 1'b0;
      mem_re_next    = 1'b0;
      mem_addr_next  = mem_addr_reg;
      mem_wdata_next = mem_wdata_reg;

      case (state_reg)
         IDLE: begin
            if (|req) begin
               gnt_next[sel] = 1'b1;
               last_next     = sel;
               if (!sel_op) begin
                  if (full) begin
                     state_next = REJECT;
                  end else begin
                     state_next     = PUSH;
                     mem_we_next    = 1'b1;
                     mem_addr_next  = sp_reg;
                     mem_wdata_next = sel_wdata;
                  end
               end else begin
                  if (empty) begin
                     state_next = REJECT;
                  end else begin
                     state_next    = POP_RD;
                     mem_re_next   = 1'b1;
                     mem_addr_next = sp_reg - SP_ONE;
                  end
               end
            end
         end
         PUSH: begin
            sp_next             = sp_reg + SP_ONE;
            done_next[last_reg] = 1'b1;
            state_next          = IDLE;
         end
         POP_RD: begin
            sp_next    = sp_reg - SP_ONE;
            state_next = POP_CAP;
         end
         POP_CAP: begin
            rdata_next[last_reg] = bus.mem_rdata;
            done_next[last_reg]  = 1'b1;
            state_next           = IDLE;
         end
         REJECT: begin
            // Setting overrides a simultaneous fault_clr.
            fault_next          = 1'b1;
            done_next[last_reg] = 1'b1;
            err_next[last_reg]  = 1'b1;
            state_next          = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         sp_reg        <= '0;
         last_reg      <= 1'b1;
         fault_reg     <= 1'b0;
         gnt_reg       <= '0;
         done_reg      <= '0;
         err_reg       <= '0;
         mem_we_reg    <= 1'b0;
         mem_re_reg    <= 1'b0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
      end else begin
         state_reg     <= state_next;
         sp_reg        <= sp_next;
         last_reg      <= last_next;
         fault_reg     <= fault_next;
         gnt_reg       <= gnt_next;
         done_reg      <= done_next;
         err_reg       <= err_next;
         mem_we_reg    <= mem_we_next;
         mem_re_reg    <= mem_re_next;
         mem_addr_reg  <= mem_addr_next;
         mem_wdata_reg <= mem_wdata_next;
      end
   end

   genvar gi;
   for (gi = 0; gi < 2; gi++) begin : g_rdata
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) rdata_reg[gi] <= '0;
         else        rdata_reg[gi] <= rdata_next[gi];
      end
   end

   assign bus.a_gnt     = gnt_reg[0];
   assign bus.a_done    = done_reg[0];
   assign bus.a_err     = err_reg[0];
   assign bus.a_rdata   = rdata_reg[0];
   assign bus.b_gnt     = gnt_reg[1];
   assign bus.b_done    = done_reg[1];
   assign bus.b_err     = err_reg[1];
   assign bus.b_rdata   = rdata_reg[1];
   assign bus.mem_we    = mem_we_reg;
   assign bus.mem_re    = mem_re_reg;
   assign bus.mem_addr  = mem_addr_reg;
   assign bus.mem_wdata = mem_wdata_reg;
   assign bus.sp_out    = sp_reg;
   assign bus.full      = full;
   assign bus.empty     = empty;
   assign bus.fault     = fault_reg;
endmodule

// File: tb/tb_sp_arbiter_ctrl.sv
// Directed bench for sp_arbiter_ctrl: a vector table of single and contending
// requests plus hand sequences for fill-to-full, fault clear and reset during a pop.
module tb_sp_arbiter_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   sp_arbiter_ctrl_if #(.SP_W(5), .DATA_W(32)) bus ();

   sp_arbiter_ctrl #(.SP_W(5), .DATA_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous stack RAM model: read data valid the cycle after mem_re.
   logic [31:0] ram [0:31];
   always @(posedge clk) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr];
   end

   typedef struct {
      bit          a_en;
      bit          a_op;
      logic [31:0] a_wd;
      bit          b_en;
      bit          b_op;
      logic [31:0] b_wd;
      bit          first;
      bit          a_err;
      logic [31:0] a_rd;
      bit          b_err;
      logic [31:0] b_rd;
      logic [4:0]  sp;
   } vec_t;

   vec_t vecs [11];

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      int t0, ga, gb, da, db, nga, ngb, nwe, nre, g1, g2, d1;
      logic a_errv, b_errv;
      logic [31:0] a_rdv, b_rdv;
      ga = -1; gb = -1; da = -1; db = -1;
      nga = 0; ngb = 0; nwe = 0; nre = 0;
      a_errv = 1'b0; b_errv = 1'b0; a_rdv = '0; b_rdv = '0;
      bus.a_req = v.a_en; bus.a_op = v.a_op; bus.a_wdata = v.a_wd;
      bus.b_req = v.b_en; bus.b_op = v.b_op; bus.b_wdata = v.b_wd;
      t0 = cyc;
      for (int k = 0; k < 16; k++) begin
         @(posedge clk); #1;
         if (bus.a_gnt) begin nga++; if (ga < 0) ga = cyc; bus.a_req = 1'b0; end
         if (bus.b_gnt) begin ngb++; if (gb < 0) gb = cyc; bus.b_req = 1'b0; end
         if (bus.mem_we) nwe++;
         if (bus.mem_re) nre++;
         if (bus.a_done && da < 0) begin da = cyc; a_errv = bus.a_err; a_rdv = bus.a_rdata; end
         if (bus.b_done && db < 0) begin db = cyc; b_errv = bus.b_err; b_rdv = bus.b_rdata; end
         if ((!v.a_en || da >= 0) && (!v.b_en || db >= 0)) break;
      end
      bus.a_req = 1'b0; bus.b_req = 1'b0;
      chk({nm, " a_gnt pulses"}, 64'(nga), 64'(v.a_en));
      chk({nm, " b_gnt pulses"}, 64'(ngb), 64'(v.b_en));
      chk({nm, " a_done seen"}, 64'(da >= 0), 64'(v.a_en));
      chk({nm, " b_done seen"}, 64'(db >= 0), 64'(v.b_en));
      g1 = v.first ? gb : ga;
      g2 = v.first ? ga : gb;
      d1 = v.first ? db : da;
      chk({nm, " first gnt cycle"}, 64'(g1), 64'(t0 + 1));
      if (v.a_en && v.b_en)
         chk({nm, " second gnt cycle"}, 64'(g2), 64'(d1 + 1));
      if (v.a_en && da >= 0) begin
         chk({nm, " a_done latency"}, 64'(da - ga), 64'((v.a_op && !v.a_err) ? 2 : 1));
         chk({nm, " a_err"}, 64'(a_errv), 64'(v.a_err));
         if (v.a_op && !v.a_err) chk({nm, " a_rdata"}, 64'(a_rdv), 64'(v.a_rd));
      end
      if (v.b_en && db >= 0) begin
         chk({nm, " b_done latency"}, 64'(db - gb), 64'((v.b_op && !v.b_err) ? 2 : 1));
         chk({nm, " b_err"}, 64'(b_errv), 64'(v.b_err));
         if (v.b_op && !v.b_err) chk({nm, " b_rdata"}, 64'(b_rdv), 64'(v.b_rd));
      end
      chk({nm, " mem_we count"}, 64'(nwe),
          64'(int'(v.a_en && !v.a_op && !v.a_err) + int'(v.b_en && !v.b_op && !v.b_err)));
      chk({nm, " mem_re count"}, 64'(nre),
          64'(int'(v.a_en && v.a_op && !v.a_err) + int'(v.b_en && v.b_op && !v.b_err)));
      chk({nm, " sp_out"}, 64'(bus.sp_out), 64'(v.sp));
      $display("txn %s: a_gnt@%0d b_gnt@%0d a_done@%0d b_done@%0d sp=%0d",
               nm, ga, gb, da, db, bus.sp_out);
   endtask

   initial begin
      vec_t v;
      int   gcyc, ndone;
      bus.a_req = 1'b0; bus.a_op = 1'b0; bus.a_wdata = '0;
      bus.b_req = 1'b0; bus.b_op = 1'b0; bus.b_wdata = '0;
      bus.fault_clr = 1'b0;

      //            a_en a_op a_wd     b_en b_op b_wd     first a_err a_rd     b_err b_rd     sp
      vecs[0]  = '{1'b1, 1'b0, 32'h11, 1'b1, 1'b0, 32'h22, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  5'd2};
      vecs[1]  = '{1'b1, 1'b0, 32'h33, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  5'd3};
      vecs[2]  = '{1'b1, 1'b1, 32'h0,  1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h33, 1'b0, 32'h0,  5'd2};
      vecs[3]  = '{1'b1, 1'b0, 32'hA1, 1'b1, 1'b0, 32'hB1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  5'd4};
      vecs[4]  = '{1'b1, 1'b1, 32'h0,  1'b1, 1'b1, 32'h0,  1'b1, 1'b0, 32'hB1, 1'b0, 32'hA1, 5'd2};
      vecs[5]  = '{1'b1, 1'b1, 32'h0,  1'b1, 1'b0, 32'hB2, 1'b1, 1'b0, 32'hB2, 1'b0, 32'h0,  5'd2};
      vecs[6]  = '{1'b1, 1'b0, 32'hA2, 1'b1, 1'b1, 32'h0,  1'b1, 1'b0, 32'h0,  1'b0, 32'h22, 5'd2};
      vecs[7]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h0,  1'b1, 1'b0, 32'h0,  1'b0, 32'hA2, 5'd1};
      vecs[8]  = '{1'b1, 1'b1, 32'h0,  1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h11, 1'b0, 32'h0,  5'd0};
      vecs[9]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h0,  1'b1, 1'b0, 32'h0,  1'b1, 32'h0,  5'd0};
      vecs[10] = '{1'b1, 1'b1, 32'h0,  1'b1, 1'b1, 32'h0,  1'b0, 1'b1, 32'h0,  1'b1, 32'h0,  5'd0};

      repeat (3) @(posedge clk);
      #1;
      chk("reset sp_out", 64'(bus.sp_out), 64'd0);
      chk("reset empty", 64'(bus.empty), 64'd1);
      chk("reset full", 64'(bus.full), 64'd0);
      chk("reset fault", 64'(bus.fault), 64'd0);
      chk("reset gnt/done/err", 64'({bus.a_gnt, bus.b_gnt, bus.a_done, bus.b_done, bus.a_err, bus.b_err}), 64'd0);
      chk("reset mem_we/mem_re", 64'({bus.mem_we, bus.mem_re}), 64'd0);
      chk("reset rdata", 64'(bus.a_rdata | bus.b_rdata), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      chk("ram[1] after table", 64'(ram[1]), 64'hA2);
      chk("ram[2] after table", 64'(ram[2]), 64'hB2);
      chk("ram[3] after table", 64'(ram[3]), 64'hA1);
      chk("fault after underflow", 64'(bus.fault), 64'd1);

      bus.fault_clr = 1'b1;
      @(posedge clk); #1;
      bus.fault_clr = 1'b0;
      chk("fault after fault_clr", 64'(bus.fault), 64'd0);
      $display("txn fault_clr: fault=%0d", bus.fault);

      for (int i = 0; i < 31; i++) begin
         v = '{1'b1, 1'b0, 32'h100 + 32'(i), 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 5'(i + 1)};
         run_vec(v, $sformatf("fill%0d", i));
      end
      chk("full at sp 31", 64'(bus.full), 64'd1);
      chk("empty at sp 31", 64'(bus.empty), 64'd0);

      v = '{1'b1, 1'b0, 32'h999, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 5'd31};
      run_vec(v, "overflow");
      chk("fault after overflow", 64'(bus.fault), 64'd1);

      v = '{1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h11E, 1'b0, 32'h0, 5'd30};
      run_vec(v, "pop_after_full");
      chk("full after pop", 64'(bus.full), 64'd0);

      // Reset while the pop is in its RAM-read cycle.
      bus.b_req = 1'b1; bus.b_op = 1'b1;
      gcyc = -1;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (bus.b_gnt) begin gcyc = cyc; break; end
      end
      bus.b_req = 1'b0;
      chk("midpop gnt seen", 64'(gcyc >= 0), 64'd1);
      chk("midpop mem_re in POP_RD", 64'(bus.mem_re), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("midpop mem_re cleared", 64'(bus.mem_re), 64'd0);
      chk("midpop b_gnt cleared", 64'(bus.b_gnt), 64'd0);
      chk("midpop sp_out cleared", 64'(bus.sp_out), 64'd0);
      chk("midpop fault cleared", 64'(bus.fault), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      ndone = 0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         if (bus.b_done || bus.a_done) ndone++;
      end
      chk("midpop no done after reset", 64'(ndone), 64'd0);
      chk("midpop empty after reset", 64'(bus.empty), 64'd1);
      $display("txn reset_mid_pop: gnt@%0d sp=%0d", gcyc, bus.sp_out);

      v = '{1'b1, 1'b0, 32'h55, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 5'd1};
      run_vec(v, "push_after_reset");
      chk("ram[0] after reset push", 64'(ram[0]), 64'h55);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
